multibit_fifo_buffer: RTL and testbench
=======================================

Name: multibit_fifo_buffer

Overview:
- Parametrised single-clock sample FIFO with valid/ready on both sides, for buffering audio sample words between producer and consumer stages inside one clock domain.
- Generalises the 2-entry toggle-pointer FIFO to DEPTH entries.
- Adds occupancy count, almost-full/almost-empty thresholds, synchronous flush, sticky overflow/underflow flags, and an optional overwrite-oldest mode for real-time streams that must not stall the producer.

Parameters:
- DATA_WIDTH, 32, sample word width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH; range 1..DEPTH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH; range 0..DEPTH-1.
- OVERWRITE, 0, 0 = backpressure when full; 1 = accept when full and discard the oldest entry.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  producer data valid.
- s_data  in  DATA_WIDTH  producer data.
- s_ready  out  1  FIFO can accept.
- m_valid  out  1  FIFO holds data.
- m_data  out  DATA_WIDTH  head-of-FIFO data.
- m_ready  in  1  consumer accepts.
- flush  in  1  synchronous clear of contents.
- clr_flags  in  1  synchronous clear of sticky flags.
- count  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- overflow  out  1  sticky: push refused (OVERWRITE=0) or entry discarded (OVERWRITE=1).
- underflow  out  1  sticky: m_ready asserted while m_valid=0.

Behaviour:
- Reset: rptr, wptr, count = 0; overflow, underflow = 0; m_valid = 0; s_ready = 1; almost_full = 0; almost_empty = 1. Memory contents are not reset; m_data is undefined until the first push.
- Storage: DEPTH x DATA_WIDTH array. Pointers are $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - empty = (rptr == wptr).
  - full = address bits equal and wrap bits differ.
- push = s_valid & s_ready. pop = m_valid & m_ready.
- s_ready:
  - OVERWRITE=0: s_ready = ~full, decoded from registered pointers only. There is no combinational path from m_ready, so a full FIFO refuses a push even when a pop occurs in the same cycle.
  - OVERWRITE=1: s_ready = 1 except during flush.
- m_valid = ~empty. m_data = mem[rptr address bits], combinational read (first-word fall-through).
- Latency: push at edge N into an empty FIFO gives m_valid=1 with that word after edge N, i.e. one cycle.
- Ordering: strict FIFO; pointers wrap modulo DEPTH.
- Per-cycle update, in priority order:
  1. flush=1: rptr=wptr=0, count=0. Same-cycle push and pop are ignored and s_ready=0 during flush. Sticky flags are unaffected.
  2. push & pop: write at wptr, both pointers advance, count unchanged.
  3. push only, not full: write, wptr+1, count+1.
  4. push only, full (OVERWRITE=1 only): write at wptr, wptr+1, rptr+1, count stays DEPTH, overflow <= 1.
  5. pop only: rptr+1, count-1.
- overflow, OVERWRITE=0: set when s_valid=1 & full & ~flush.
- underflow: set when m_ready=1 & empty & ~flush.
- Sticky flags: clr_flags=1 clears both flags. A set event in the same cycle as clr_flags wins (flag = 1).
- count, almost_full, almost_empty are all registered or derived from registered state, and are consistent in the same cycle.
- Reset asserted mid-stream: immediately returns to the reset state. Data in flight is lost. No output glitches to m_valid=1 during reset.

Test Plan:
- Fill/drain: DEPTH=8, OVERWRITE=0. Push 0x1..0x8 with m_ready=0, then push 0x9.
  - After eight pushes: s_ready=0, count=8, almost_full=1.
  - 0x9 is refused and overflow=1.
  - Drain with m_ready=1: reads return 0x1..0x8 in order; then m_valid=0, almost_empty=1.
- Streaming: s_valid and m_ready held at 1 for 20 cycles with an incrementing counter.
  - count stays at 1 after the first push.
  - Output equals input delayed by one cycle; wrap-around is exercised twice with no loss.
- Full plus simultaneous pop, OVERWRITE=0: full FIFO, s_valid=1 and m_ready=1 in the same cycle.
  - The pop happens and the push is refused; count goes 8 -> 7.
  - Next cycle s_ready=1.
- Overwrite, OVERWRITE=1: push 0x1..0xA with m_ready=0.
  - count=8, overflow=1.
  - Drain returns 0x3..0xA.
- Flush and flags: count=5, assert flush together with s_valid=1 and m_ready=1.
  - Next cycle: count=0, m_valid=0, overflow still set.
  - Then pulse m_ready with the FIFO empty: underflow=1.
  - Pulse clr_flags: both flags=0.
- Reset mid-operation: count=4, assert reset asynchronously between edges.
  - Outputs immediately take reset values: m_valid=0, s_ready=1, count=0.
  - After release, the first push is read back correctly.

Source files
------------

// File: rtl/multibit_fifo_buffer_if.sv
// Valid/ready stream bundle carrying one sample word per transfer.
interface multibit_fifo_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    // Source side drives valid/data and observes ready.
    modport master (output valid, output data, input ready);
    // Sink side observes valid/data and drives ready.
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/multibit_fifo_buffer.sv
// Single-clock sample FIFO with occupancy, thresholds, flush, sticky
// error flags and an optional overwrite-oldest mode.
module multibit_fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AFULL_TH   = 6,
    parameter int unsigned AEMPTY_TH  = 2,
    parameter int unsigned OVERWRITE  = 0,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    multibit_fifo_buffer_if.slave  s,
    multibit_fifo_buffer_if.master m,
    input  logic                   flush,
    input  logic                   clr_flags,
    output logic [CNT_W-1:0]       count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rptr, wptr, rptr_nxt, wptr_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  overflow_nxt, underflow_nxt;
    logic                  ovf_evt, udf_evt;
    logic                  empty, full, push, pop;

    // Status decoded from registered pointers; the pointer MSB is the wrap bit.
    assign empty = (rptr == wptr);
    assign full  = (rptr[AW-1:0] == wptr[AW-1:0]) && (rptr[AW] != wptr[AW]);

    // Overwrite mode never stalls the producer; flush always blocks a push.
    assign s.ready = ~flush & ((OVERWRITE != 0) | ~full);
    assign m.valid = ~empty;
    assign m.data  = mem[rptr[AW-1:0]];

    assign push = s.valid & s.ready;
    assign pop  = m.valid & m.ready & ~flush;

    assign almost_full  = (count >= CNT_W'(AFULL_TH));
    assign almost_empty = (count <= CNT_W'(AEMPTY_TH));

    // Next pointers, occupancy and flag events in flush > push/pop priority.
    always_comb begin
        rptr_nxt  = rptr;
        wptr_nxt  = wptr;
        count_nxt = count;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        if (flush) begin
            rptr_nxt  = '0;
            wptr_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (push) begin
                wptr_nxt = wptr + PW'(1);
            end
            // A push into a full FIFO only gets here in overwrite mode; it evicts the head.
            if (pop || (push && full)) begin
                rptr_nxt = rptr + PW'(1);
            end
            if (push && !pop && !full) begin
                count_nxt = count + CNT_W'(1);
            end else if (pop && !push) begin
                count_nxt = count - CNT_W'(1);
            end
            if (OVERWRITE != 0) begin
                ovf_evt = push & full & ~pop;
            end else begin
                ovf_evt = s.valid & full;
            end
            udf_evt = m.ready & empty;
        end
        overflow_nxt  = ovf_evt | (overflow & ~clr_flags);
        underflow_nxt = udf_evt | (underflow & ~clr_flags);
    end

    // Pointer, occupancy and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rptr      <= rptr_nxt;
            wptr      <= wptr_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Sample storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= s.data;
        end
    end
endmodule

// File: tb/tb_multibit_fifo_buffer.sv
// Directed bench for multibit_fifo_buffer: one backpressure instance and
// one overwrite-oldest instance sharing clock and reset.
module tb_multibit_fifo_buffer;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int          AF_TH = 6;
    localparam int          AE_TH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multibit_fifo_buffer_if #(.DATA_WIDTH(DW)) s0 ();
    multibit_fifo_buffer_if #(.DATA_WIDTH(DW)) m0 ();
    multibit_fifo_buffer_if #(.DATA_WIDTH(DW)) s1 ();
    multibit_fifo_buffer_if #(.DATA_WIDTH(DW)) m1 ();

    logic          flush0, clr0, flush1, clr1;
    logic [CW-1:0] cnt0, cnt1;
    logic          af0, ae0, ovf0, udf0;
    logic          af1, ae1, ovf1, udf1;

    multibit_fifo_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .OVERWRITE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .s(s0), .m(m0), .flush(flush0), .clr_flags(clr0),
        .count(cnt0), .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(udf0)
    );

    multibit_fifo_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .OVERWRITE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .s(s1), .m(m1), .flush(flush1), .clr_flags(clr1),
        .count(cnt1), .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(udf1)
    );

    typedef struct {
        bit          sel;   // 0 = backpressure instance, 1 = overwrite instance
        logic        sv;
        logic [31:0] d;
        logic        mr;
        logic        fl;
        logic        cl;
        logic [31:0] e_md;
        logic        e_sr;
        int          e_cnt;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(bit sel, logic sv, logic [31:0] d, logic mr, logic fl, logic cl,
                                logic [31:0] md, logic sr, int cnt, logic ovf, logic udf);
        vec_t v;
        v.sel = sel; v.sv = sv; v.d = d; v.mr = mr; v.fl = fl; v.cl = cl;
        v.e_md = md; v.e_sr = sr; v.e_cnt = cnt; v.e_ovf = ovf; v.e_udf = udf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        s0.valid = 1'b0; s0.data = '0; m0.ready = 1'b0; flush0 = 1'b0; clr0 = 1'b0;
        s1.valid = 1'b0; s1.data = '0; m1.ready = 1'b0; flush1 = 1'b0; clr1 = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic        mv, sr, af, ae, ovf, udf;
        logic [31:0] md;
        int          cnt;
        if (v.sel == 1'b0) begin
            s0.valid = v.sv; s0.data = v.d; m0.ready = v.mr; flush0 = v.fl; clr0 = v.cl;
        end else begin
            s1.valid = v.sv; s1.data = v.d; m1.ready = v.mr; flush1 = v.fl; clr1 = v.cl;
        end
        @(posedge clk);
        #1;
        idle();
        #1;
        if (v.sel == 1'b0) begin
            mv = m0.valid; md = m0.data; sr = s0.ready; cnt = int'(cnt0);
            af = af0; ae = ae0; ovf = ovf0; udf = udf0;
        end else begin
            mv = m1.valid; md = m1.data; sr = s1.ready; cnt = int'(cnt1);
            af = af1; ae = ae1; ovf = ovf1; udf = udf1;
        end
        check({tag, " count"}, 32'(cnt), 32'(v.e_cnt));
        check({tag, " m_valid"}, 32'(mv), 32'(v.e_cnt != 0));
        if (v.e_cnt != 0) check({tag, " m_data"}, md, v.e_md);
        check({tag, " s_ready"}, 32'(sr), 32'(v.e_sr));
        check({tag, " almost_full"}, 32'(af), 32'(v.e_cnt >= AF_TH));
        check({tag, " almost_empty"}, 32'(ae), 32'(v.e_cnt <= AE_TH));
        check({tag, " overflow"}, 32'(ovf), 32'(v.e_ovf));
        check({tag, " underflow"}, 32'(udf), 32'(v.e_udf));
    endtask

    initial begin
        // Backpressure instance: fill, refused push, drain.
        for (int k = 1; k <= 8; k++) va.push_back(mk(0, 1, 32'(k), 0, 0, 0, 32'h1, k < 8, k, 0, 0));
        va.push_back(mk(0, 1, 32'h9, 0, 0, 0, 32'h1, 0, 8, 1, 0));
        for (int i = 1; i <= 8; i++) va.push_back(mk(0, 0, 0, 1, 0, 0, 32'(i + 1), 1, 8 - i, 1, 0));
        // Streaming: one entry in flight, pointers wrap twice.
        va.push_back(mk(0, 1, 32'h100, 0, 0, 0, 32'h100, 1, 1, 1, 0));
        for (int k = 1; k <= 20; k++) va.push_back(mk(0, 1, 32'(32'h100 + k), 1, 0, 0, 32'(32'h100 + k), 1, 1, 1, 0));
        va.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        // Flush with concurrent push/pop, then underflow, then clear flags.
        for (int k = 0; k < 5; k++) va.push_back(mk(0, 1, 32'(32'h20 + k), 0, 0, 0, 32'h20, 1, k + 1, 1, 0));
        va.push_back(mk(0, 1, 32'hFF, 1, 1, 0, 0, 1, 0, 1, 0));
        va.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        va.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        // Refill for the full-plus-pop case.
        for (int k = 0; k < 8; k++) va.push_back(mk(0, 1, 32'(32'h30 + k), 0, 0, 0, 32'h30, k < 7, k + 1, 0, 0));

        // Drain after the refused push: 0xEE must never appear.
        for (int i = 1; i <= 7; i++) vb.push_back(mk(0, 0, 0, 1, 0, 0, 32'(32'h31 + i), 1, 7 - i, 1, 0));
        // Overwrite instance: ten pushes keep the newest eight.
        for (int k = 1; k <= 10; k++)
            vb.push_back(mk(1, 1, 32'(k), 0, 0, 0, (k <= 8) ? 32'h1 : 32'(k - 7), 1, (k < 8) ? k : 8, k > 8, 0));
        for (int i = 1; i <= 8; i++) vb.push_back(mk(1, 0, 0, 1, 0, 0, 32'(i + 3), 1, 8 - i, 1, 0));
        // Occupancy of four before the asynchronous reset.
        for (int k = 0; k < 4; k++) vb.push_back(mk(0, 1, 32'(32'h40 + k), 0, 0, 0, 32'h40, 1, k + 1, 1, 0));

        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset count", 32'(cnt0), 32'd0);
        check("reset m_valid", 32'(m0.valid), 32'd0);
        check("reset s_ready", 32'(s0.ready), 32'd1);
        check("reset almost_full", 32'(af0), 32'd0);
        check("reset almost_empty", 32'(ae0), 32'd1);
        check("reset overflow", 32'(ovf0), 32'd0);
        check("reset underflow", 32'(udf0), 32'd0);
        check("reset m_valid ovw", 32'(m1.valid), 32'd0);

        foreach (va[i]) apply(va[i], $sformatf("va%0d", i));

        // Full FIFO with push and pop offered together: pop wins, push refused.
        s0.valid = 1'b1; s0.data = 32'hEE; m0.ready = 1'b1;
        #1;
        check("fullpop s_ready pre", 32'(s0.ready), 32'd0);
        check("fullpop head pre", m0.data, 32'h30);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("fullpop count", 32'(cnt0), 32'd7);
        check("fullpop s_ready", 32'(s0.ready), 32'd1);
        check("fullpop head", m0.data, 32'h31);
        check("fullpop overflow", 32'(ovf0), 32'd1);

        foreach (vb[i]) apply(vb[i], $sformatf("vb%0d", i));

        // Asynchronous reset between edges takes effect immediately.
        #1;
        reset = 1'b1;
        #1;
        check("async count", 32'(cnt0), 32'd0);
        check("async m_valid", 32'(m0.valid), 32'd0);
        check("async s_ready", 32'(s0.ready), 32'd1);
        check("async almost_empty", 32'(ae0), 32'd1);
        check("async overflow", 32'(ovf0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(0, 1, 32'h55, 0, 0, 0, 32'h55, 1, 1, 0, 0), "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
